// File: rtl/trunc_seq_div.sv
// rtl/trunc_seq_div.sv - truncated-operand sequential restoring divider, one quotient bit per clock
// Optional quotient rounding stage compiled in with TRUNC_DIV_ROUND_EN.
module trunc_seq_div #(
    parameter int BWOP = 10,
    parameter int NAB  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BWOP-1:0] a,
    input  logic [BWOP-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BWOP-1:0] q,
    output logic [BWOP-1:0] r,
    output logic            dz
);

    localparam int W  = BWOP - NAB;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RND, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BWOP-1:0] q_q, q_d;
    logic [BWOP-1:0] r_q, r_d;
    logic            dz_q, dz_d;

    logic [W-1:0]    a_t, b_t;
    logic [W:0]      rem_sh;
    logic            step_ge;
    logic [W-1:0]    rem_step;
    logic [W-1:0]    quo_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        r_d      = r_q;
        dz_d     = dz_q;

        a_t      = W'(a >> NAB);
        b_t      = W'(b >> NAB);
        // Remainder stays below the divisor, so W+1 bits covers the shifted compare.
        rem_sh   = {rem_q, dvd_q[W-1]};
        step_ge  = (rem_sh >= {1'b0, dvs_q});
        rem_step = step_ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
        quo_step = W'({quo_q, step_ge});

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d = a_t;
                    dvs_d = b_t;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = CW'(W - 1);
                    if (b_t == '0) begin
                        state_d = S_DONE;
                        q_d     = BWOP'({W{1'b1}});
                        r_d     = a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d = dvd_q << 1;
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    r_d  = BWOP'(rem_step) << NAB;
                    dz_d = 1'b0;
`ifdef TRUNC_DIV_ROUND_EN
                    state_d = S_RND;
`else
                    state_d = S_DONE;
                    q_d     = BWOP'(quo_step);
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef TRUNC_DIV_ROUND_EN
            S_RND: begin
                // Round half up on the truncated operands; an all-ones quotient must not wrap.
                if (({rem_q, 1'b0} >= {1'b0, dvs_q}) && (quo_q != '1)) begin
                    q_d = BWOP'(quo_q + W'(1));
                end else begin
                    q_d = BWOP'(quo_q);
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_trunc_seq_div.sv
// tb/tb_trunc_seq_div.sv - directed self-checking bench for trunc_seq_div (NAB=1 and NAB=0 instances)
module tb_trunc_seq_div;

`ifdef TRUNC_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic [9:0] a0 = '0, b0 = '0;
    logic       in_ready0, out_valid0, dz0;
    logic [9:0] q0, r0;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [9:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, dz1;
    logic [9:0] q1, r1;

    int errors = 0;
    int checks = 0;

    trunc_seq_div #(.BWOP(10), .NAB(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
        .out_valid(out_valid0), .out_ready(out_ready0), .q(q0), .r(r0), .dz(dz0)
    );

    trunc_seq_div #(.BWOP(10), .NAB(0)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .q(q1), .r(r1), .dz(dz1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Latency counts edges after the accepting edge until out_valid is seen.
    task automatic run_op0(input logic [9:0] av, input logic [9:0] bv, output int lat);
        @(negedge clk);
        in_valid0 = 1'b1; a0 = av; b0 = bv;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op1(input logic [9:0] av, input logic [9:0] bv, output int lat);
        @(negedge clk);
        in_valid1 = 1'b1; a1 = av; b1 = bv;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept0();
        @(negedge clk); out_ready0 = 1'b1;
        @(posedge clk); #1; out_ready0 = 1'b0;
    endtask

    task automatic accept1();
        @(negedge clk); out_ready1 = 1'b1;
        @(posedge clk); #1; out_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
        checks++; if (q0 !== 10'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q0); end
        checks++; if (r0 !== 10'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", r0); end
        checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", dz0); end
        checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            errors++; $display("FAIL reset_nab0 got in_ready=%b out_valid=%b exp 1/0", in_ready1, out_valid1);
        end
    endtask

    task automatic test_divide();
        logic [9:0] ta [4];
        logic [9:0] tb [4];
        logic [9:0] tq [4];
        logic [9:0] tr [4];
        int lat;
        ta = '{10'd100, 10'd1022, 10'd110, 10'd200};
        tb = '{10'd7,   10'd2,    10'd40,  10'd60};
        tq = '{10'(16 + RND), 10'd511, 10'(2 + RND), 10'd3};
        tr = '{10'd4,   10'd0,    10'd30,  10'd20};
        for (int i = 0; i < 4; i++) begin
            run_op0(ta[i], tb[i], lat);
            checks++; if (lat !== 9 + RND) begin errors++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, 9 + RND); end
            checks++; if (q0 !== tq[i]) begin errors++; $display("FAIL div%0d_q got=%0d exp=%0d", i, q0, tq[i]); end
            checks++; if (r0 !== tr[i]) begin errors++; $display("FAIL div%0d_r got=%0d exp=%0d", i, r0, tr[i]); end
            checks++; if (dz0 !== 1'b0) begin errors++; $display("FAIL div%0d_dz got=%b exp=0", i, dz0); end
            accept0();
            checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
                errors++; $display("FAIL div%0d_release got out_valid=%b in_ready=%b exp 0/1", i, out_valid0, in_ready0);
            end
        end
    endtask

    task automatic test_divzero();
        logic [9:0] ta [2];
        logic [9:0] tb [2];
        int lat;
        ta = '{10'd300, 10'd77};
        tb = '{10'd1,   10'd0};
        for (int i = 0; i < 2; i++) begin
            run_op0(ta[i], tb[i], lat);
            checks++; if (lat !== 0) begin errors++; $display("FAIL dz%0d_latency got=%0d exp=0", i, lat); end
            checks++; if (q0 !== 10'd511) begin errors++; $display("FAIL dz%0d_q got=%0d exp=511", i, q0); end
            checks++; if (r0 !== ta[i]) begin errors++; $display("FAIL dz%0d_r got=%0d exp=%0d", i, r0, ta[i]); end
            checks++; if (dz0 !== 1'b1) begin errors++; $display("FAIL dz%0d_flag got=%b exp=1", i, dz0); end
            accept0();
        end
    endtask

    task automatic test_stall();
        int lat;
        run_op0(10'd100, 10'd7, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid0 = 1'b1; a0 = 10'd5; b0 = 10'd5;
            @(posedge clk); #1;
            in_valid0 = 1'b0;
            checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
                errors++; $display("FAIL stall%0d_hs got out_valid=%b in_ready=%b exp 1/0", i, out_valid0, in_ready0);
            end
            checks++; if (q0 !== 10'(16 + RND) || r0 !== 10'd4 || dz0 !== 1'b0) begin
                errors++; $display("FAIL stall%0d_data got q=%0d r=%0d dz=%b exp q=%0d r=4 dz=0", i, q0, r0, dz0, 16 + RND);
            end
        end
        accept0();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++; $display("FAIL stall_no_capture got out_valid=%b in_ready=%b exp 0/1", out_valid0, in_ready0);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_valid0 = 1'b1; a0 = 10'd200; b0 = 10'd60;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL calc_in_ready got=%b exp=0", in_ready0); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            errors++; $display("FAIL midrst_state got in_ready=%b out_valid=%b exp 1/0", in_ready0, out_valid0);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_no_result got=%b exp=0", out_valid0); end
        run_op0(10'd100, 10'd7, lat);
        checks++; if (lat !== 9 + RND || q0 !== 10'(16 + RND) || r0 !== 10'd4) begin
            errors++; $display("FAIL midrst_next got lat=%0d q=%0d r=%0d exp lat=%0d q=%0d r=4", lat, q0, r0, 9 + RND, 16 + RND);
        end
        accept0();
    endtask

    task automatic test_nab0();
        int lat;
        run_op1(10'd1023, 10'd1, lat);
        checks++; if (lat !== 10 + RND) begin errors++; $display("FAIL nab0_a_latency got=%0d exp=%0d", lat, 10 + RND); end
        checks++; if (q1 !== 10'd1023) begin errors++; $display("FAIL nab0_a_q got=%0d exp=1023", q1); end
        checks++; if (r1 !== 10'd0 || dz1 !== 1'b0) begin errors++; $display("FAIL nab0_a_r got r=%0d dz=%b exp 0/0", r1, dz1); end
        accept1();
        run_op1(10'd5, 10'd9, lat);
        checks++; if (q1 !== 10'(RND)) begin errors++; $display("FAIL nab0_b_q got=%0d exp=%0d", q1, RND); end
        checks++; if (r1 !== 10'd5) begin errors++; $display("FAIL nab0_b_r got=%0d exp=5", r1); end
        accept1();
    endtask

    initial begin
        test_reset();
        test_divide();
        test_divzero();
        test_stall();
        test_reset_mid();
        test_nab0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
